seg_display_arbiter: RTL and testbench

Shares the single 8-digit seven-segment display between several frame producers: the error/countdown banner, the mode banner, and the matrix result viewer. The block grants the display to one requester at a time by fixed priority, enforces a minimum on-screen hold time, and inserts a one-cycle blank gap on every owner change. It optionally blinks the owner's frame and drives a registered 64-bit frame into the existing scan driver.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_blink_gen.sv | 38 +++
 rtl/seg_display_arbiter.sv | 128 ++++++++++++
 tb/tb_seg_display_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
// Segment codes are active-low, bit 7 = dp, bits 6:0 = g..a.
package seg_pkg;

  localparam logic [63:0] BLANK_FRAME = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [7:0] GLYPH_0     = 8'hC0;
  localparam logic [7:0] GLYPH_1     = 8'hF9;
  localparam logic [7:0] GLYPH_2     = 8'hA4;
  localparam logic [7:0] GLYPH_3     = 8'hB0;
  localparam logic [7:0] GLYPH_4     = 8'h99;
  localparam logic [7:0] GLYPH_5     = 8'h92;
  localparam logic [7:0] GLYPH_6     = 8'h82;
  localparam logic [7:0] GLYPH_7     = 8'hF8;
  localparam logic [7:0] GLYPH_8     = 8'h80;
  localparam logic [7:0] GLYPH_9     = 8'h90;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } arb_state_t;

endpackage

// File: rtl/seg_blink_gen.sv
// Blink phase counter; restart forces the visible phase and clears the count.
// hidden_nxt is the phase that will hold after the coming edge.
module seg_blink_gen #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic hidden_nxt
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign hidden_nxt = !restart && (wrap ? ~phase : phase);

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner of the 8-digit display: minimum hold, blank gap
// on owner change, optional blink, registered frame to the scan driver.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MIN_HOLD  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*64-1:0] frame_in,
  input  logic [NUM_REQ-1:0]    blink,
  output logic [NUM_REQ-1:0]    grant,
  output logic [OW-1:0]         owner,
  output logic [63:0]           frame_out,
  output logic                  switch_pulse
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  arb_state_t state_q, state_d;
  logic [OW-1:0] owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [63:0] frame_d, sel_frame;
  logic sel_blink, hidden_nxt, new_grant;
  logic own_req, others, higher;

  function automatic logic [OW-1:0] pick(input logic [NUM_REQ-1:0] r);
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (r[i]) pick = OW'(i);
  endfunction

  always_comb begin
    own_req = 1'b0;
    others  = 1'b0;
    higher  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OW'(i) == owner) own_req = req[i];
      else if (req[i]) others = 1'b1;
      if (OW'(i) < owner && req[i]) higher = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner;
    unique case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d = OWN;
          owner_d = pick(req);
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        // a release wins over any simultaneous preemption
        if (!own_req)
          state_d = others ? GAP : IDLE;
        else if (req[0] && owner != '0)
          state_d = GAP;
        else if (hold_q == HOLD_MAX && higher)
          state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign new_grant = (state_d == OWN) && (state_q != OWN);

  always_comb begin
    grant_d   = '0;
    sel_frame = BLANK_FRAME;
    sel_blink = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OW'(i) == owner_d) begin
        grant_d[i] = (state_d == OWN);
        sel_frame  = frame_in[i*64 +: 64];
        sel_blink  = blink[i];
      end
    end
    frame_d = BLANK_FRAME;
    if (state_d == OWN && !(sel_blink && hidden_nxt))
      frame_d = sel_frame;
  end

  always_comb begin
    hold_d = hold_q;
    if (new_grant)
      hold_d = '0;
    else if (state_q == OWN && hold_q != HOLD_MAX)
      hold_d = hold_q + HW'(1);
  end

  seg_blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (new_grant),
    .hidden_nxt (hidden_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner        <= '0;
      hold_q       <= '0;
      grant        <= '0;
      frame_out    <= BLANK_FRAME;
      switch_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner        <= owner_d;
      hold_q       <= hold_d;
      grant        <= grant_d;
      frame_out    <= frame_d;
      switch_pulse <= new_grant;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with MIN_HOLD=8, BLINK_DIV=4.
// A vector table drives one row per clock; reset cases are hand-written.
module tb_seg_display_arbiter;

  localparam logic [63:0] BLK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] F0  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] F1  = 64'hA1A2_A3A4_A5A6_A7A8;
  localparam logic [63:0] F2  = 64'hC0F9_A4B0_9992_82F8;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  blink;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic        pulse;
    logic [63:0] frame;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req;
  logic [191:0] frame_in;
  logic [2:0]   blink;
  logic [2:0]   grant;
  logic [1:0]   owner;
  logic [63:0]  frame_out;
  logic         switch_pulse;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  assign frame_in = {F2, F1, F0};

  seg_display_arbiter #(
    .NUM_REQ   (3),
    .MIN_HOLD  (8),
    .BLINK_DIV (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .frame_in     (frame_in),
    .blink        (blink),
    .grant        (grant),
    .owner        (owner),
    .frame_out    (frame_out),
    .switch_pulse (switch_pulse)
  );

  task automatic chk(input string name, input int row,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] b,
                     input logic [2:0] g, input logic [1:0] o,
                     input logic p, input logic [63:0] f);
    vec_t v;
    v.req = r; v.blink = b; v.grant = g;
    v.owner = o; v.pulse = p; v.frame = f;
    tbl.push_back(v);
  endtask

  task automatic chk_reset(input int tag);
    chk("rst_grant", tag, 64'(grant), 64'(3'b000));
    chk("rst_owner", tag, 64'(owner), 64'(2'd0));
    chk("rst_frame", tag, frame_out, BLK);
    chk("rst_pulse", tag, 64'(switch_pulse), 64'(1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single requester, then drop
    add(3'b100, 0, 3'b100, 2, 1, F2);
    add(3'b100, 0, 3'b100, 2, 0, F2);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    // lower priority never preempts owner 0
    add(3'b001, 0, 3'b001, 0, 1, F0);
    for (int i = 0; i < 10; i++)
      add(3'b101, 0, 3'b001, 0, 0, F0);
    add(3'b100, 0, 3'b000, 0, 0, BLK);
    add(3'b100, 0, 3'b100, 2, 1, F2);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    // urgent preemption ignores hold
    add(3'b010, 0, 3'b010, 1, 1, F1);
    add(3'b011, 0, 3'b000, 0, 0, BLK);
    add(3'b011, 0, 3'b001, 0, 1, F0);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    // hold enforcement: req[1] raised 3 cycles after grant
    add(3'b100, 0, 3'b100, 2, 1, F2);
    add(3'b100, 0, 3'b100, 2, 0, F2);
    add(3'b100, 0, 3'b100, 2, 0, F2);
    for (int i = 0; i < 6; i++)
      add(3'b110, 0, 3'b100, 2, 0, F2);
    add(3'b110, 0, 3'b000, 0, 0, BLK);
    add(3'b110, 0, 3'b010, 1, 1, F1);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    // blink: 4 visible, 4 hidden, from the grant
    add(3'b010, 3'b010, 3'b010, 1, 1, F1);
    for (int i = 0; i < 3; i++)
      add(3'b010, 3'b010, 3'b010, 1, 0, F1);
    for (int i = 0; i < 4; i++)
      add(3'b010, 3'b010, 3'b010, 1, 0, BLK);
    for (int i = 0; i < 4; i++)
      add(3'b010, 3'b010, 3'b010, 1, 0, F1);
    add(3'b010, 3'b010, 3'b010, 1, 0, BLK);
    add(3'b000, 0, 3'b000, 0, 0, BLK);
    add(3'b000, 0, 3'b000, 0, 0, BLK);

    rst_n = 1'b0;
    req   = '0;
    blink = '0;
    #12;
    chk_reset(-1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req   = tbl[i].req;
      blink = tbl[i].blink;
      tick();
      chk("grant", i, 64'(grant), 64'(tbl[i].grant));
      chk("pulse", i, 64'(switch_pulse), 64'(tbl[i].pulse));
      chk("frame", i, frame_out, tbl[i].frame);
      if (tbl[i].grant != 3'b000)
        chk("owner", i, 64'(owner), 64'(tbl[i].owner));
    end

    // asynchronous reset while owning
    req = 3'b010;
    tick();
    chk("own_grant", 100, 64'(grant), 64'(3'b010));
    #2 rst_n = 1'b0;
    #1 chk_reset(100);
    #2 rst_n = 1'b1;

    // asynchronous reset in the gap, then regrant
    tick();
    chk("own_grant", 101, 64'(grant), 64'(3'b010));
    req = 3'b011;
    tick();
    chk("gap_grant", 102, 64'(grant), 64'(3'b000));
    #2 rst_n = 1'b0;
    #1 chk_reset(103);
    #2 rst_n = 1'b1;
    req = 3'b010;
    tick();
    chk("post_grant", 104, 64'(grant), 64'(3'b010));
    chk("post_owner", 104, 64'(owner), 64'(2'd1));
    chk("post_pulse", 104, 64'(switch_pulse), 64'(1'b1));
    chk("post_frame", 104, frame_out, F1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
